pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in clk cycles. It is the receive-side counterpart of the team's PWM generators: it decodes a duty cycle back out of a pin, so a fan tachometer, servo or loop-back link can be checked against a generated setting. It also flags a line stuck at a constant level (0 % or 100 % duty). Software or downstream logic computes the duty ratio as high_time / period.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 143 ++++++++++++++
 tb/tb_pwm_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default
// widths/timeouts common to the PWM generators and receivers.
package pwm_pkg;

    typedef enum logic [1:0] {
        ARM,
        HIGH,
        LOW
    } cap_state_t;

    localparam int PWM_CNT_W   = 16;
    localparam int PWM_TIMEOUT = 65535;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus a
// one-cycle-delayed copy for rising/falling edge detection.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              s_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            s_prev <= 1'b0;
        end else begin
            sr     <= {sr[STAGES-2:0], din};
            s_prev <= sr[STAGES-1];
        end
    end

    assign s    = sr[STAGES-1];
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between rising
// edges and flags a line stuck at a constant level.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic s;
    logic rise;
    logic fall;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    cap_state_t       state;
    cap_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_lat;
    logic [CNT_W-1:0] hi_lat_n;
    logic [CNT_W-1:0] period_n;
    logic [CNT_W-1:0] high_n;
    logic             valid_n;
    logic             stuck_n;
    logic             level_n;
    logic             timed_out;

    // Saturate so a fall landing on the timeout count cannot wrap
    // cnt and hide the subsequent stuck-low condition.
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + ONE;
    assign timed_out = (cnt >= TO);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_lat_n = hi_lat;
        period_n = period;
        high_n   = high_time;
        valid_n  = 1'b0;
        stuck_n  = stuck;
        level_n  = stuck_level;
        if (!enable) begin
            state_n = ARM;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ARM: begin
                    cnt_n = '0;
                    if (rise) begin
                        state_n = HIGH;
                        cnt_n   = ONE;
                    end
                end
                HIGH: begin
                    cnt_n = cnt_inc;
                    if (fall) begin
                        hi_lat_n = cnt;
                        state_n  = LOW;
                    end else if (timed_out) begin
                        stuck_n  = 1'b1;
                        level_n  = s;
                        period_n = '0;
                        high_n   = '0;
                        valid_n  = 1'b1;
                        state_n  = ARM;
                        cnt_n    = '0;
                    end
                end
                LOW: begin
                    cnt_n = cnt_inc;
                    if (rise) begin
                        period_n = cnt;
                        high_n   = hi_lat;
                        valid_n  = 1'b1;
                        stuck_n  = 1'b0;
                        state_n  = HIGH;
                        cnt_n    = ONE;
                    end else if (timed_out) begin
                        stuck_n  = 1'b1;
                        level_n  = s;
                        period_n = '0;
                        high_n   = '0;
                        valid_n  = 1'b1;
                        state_n  = ARM;
                        cnt_n    = '0;
                    end
                end
                default: begin
                    state_n = ARM;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARM;
            cnt         <= '0;
            hi_lat      <= '0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            hi_lat      <= hi_lat_n;
            period      <= period_n;
            high_time   <= high_n;
            valid       <= valid_n;
            stuck       <= stuck_n;
            stuck_level <= level_n;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed plus randomized bench for pwm_capture, checked every
// cycle against a timestamp-based model of the measurement rules.
module tb_pwm_capture;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TO = 16;
    localparam int N  = 12000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b1;
    logic         pwm_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         stuck;
    logic         stuck_level;

    pwm_capture #(
        .CNT_W       (W),
        .SYNC_STAGES (S),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int t      = 0;
    int passes = 0;
    int checks = 0;
    int nvalid = 0;

    bit drv  [N];
    bit en_h [N];
    bit rs_h [N];

    bit en_nx  = 1'b1;
    bit rst_nx = 1'b0;

    // model: timestamps of the last detected rise/fall
    bit m_armed = 1'b0;
    bit m_hp    = 1'b0;
    int m_tr    = 0;
    int m_hi    = 0;
    int e_period = 0;
    int e_high   = 0;
    bit e_valid  = 1'b0;
    bit e_stuck  = 1'b0;
    bit e_level  = 1'b0;

    function automatic bit lv(int i);
        return (i < 0) ? 1'b0 : drv[i];
    endfunction

    task automatic check(string tag, logic [31:0] obs,
                         logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s t=%0d got %0d exp %0d",
                    tag, t, obs, exp);
    endtask

    task automatic model();
        bit r;
        bit f;
        int age;
        e_valid = 1'b0;
        if (!rs_h[t] || !rs_h[t-1]) begin
            m_armed  = 1'b0;
            e_period = 0;
            e_high   = 0;
            e_stuck  = 1'b0;
            e_level  = 1'b0;
            return;
        end
        r = lv(t-1-S) & ~lv(t-2-S);
        f = ~lv(t-1-S) & lv(t-2-S);
        if (!en_h[t-1]) begin
            m_armed = 1'b0;
        end else if (!m_armed) begin
            if (r) begin
                m_armed = 1'b1;
                m_hp    = 1'b1;
                m_tr    = t;
            end
        end else begin
            age = t - m_tr;
            if (m_hp && f) begin
                m_hi = age;
                m_hp = 1'b0;
            end else if (!m_hp && r) begin
                e_period = age;
                e_high   = m_hi;
                e_valid  = 1'b1;
                e_stuck  = 1'b0;
                m_tr     = t;
                m_hp     = 1'b1;
            end else if (age >= TO) begin
                e_stuck  = 1'b1;
                e_level  = lv(t-1-S);
                e_period = 0;
                e_high   = 0;
                e_valid  = 1'b1;
                m_armed  = 1'b0;
            end
        end
    endtask

    task automatic step(bit p);
        @(posedge clk);
        t++;
        if (t >= N - 1) begin
            $display("FAIL budget cycles=%0d limit=%0d", t, N);
            $fatal(1, "cycle budget exceeded");
        end
        #1;
        rst_n   = rst_nx;
        enable  = en_nx;
        pwm_in  = p;
        drv[t]  = p;
        en_h[t] = en_nx;
        rs_h[t] = rst_nx;
        @(negedge clk);
        model();
        if (e_valid) nvalid++;
        check("valid", 32'(valid), 32'(e_valid));
        check("period", 32'(period), 32'(e_period));
        check("high_time", 32'(high_time), 32'(e_high));
        check("stuck", 32'(stuck), 32'(e_stuck));
        check("stuck_level", 32'(stuck_level), 32'(e_level));
    endtask

    task automatic hold(bit v, int n);
        repeat (n) step(v);
    endtask

    task automatic pwm(int h, int l, int n);
        repeat (n) begin
            repeat (h) step(1'b1);
            repeat (l) step(1'b0);
        end
    endtask

    initial begin
        int h;
        int l;
        int n;
        int v0;
        drv[0]  = 1'b0;
        en_h[0] = 1'b1;
        rs_h[0] = 1'b0;

        hold(1'b0, 4);
        rst_nx = 1'b1;
        hold(1'b0, 4);

        pwm(3, 5, 8);
        pwm(1, 1, 10);
        pwm(7, 1, 5);

        v0 = nvalid;
        hold(1'b0, 30);
        hold(1'b1, 30);
        pwm(4, 4, 5);
        check("timeout_seen", 32'(nvalid - v0 >= 2), 32'd1);

        pwm(8, 8, 4);

        pwm(3, 5, 3);
        repeat (3) step(1'b1);
        repeat (2) step(1'b0);
        en_nx = 1'b0;
        hold(1'b0, 3);
        pwm(3, 5, 2);
        en_nx = 1'b1;
        pwm(3, 5, 4);

        pwm(3, 5, 2);
        repeat (2) step(1'b1);
        rst_nx = 1'b0;
        hold(1'b0, S + 3);
        rst_nx = 1'b1;
        hold(1'b0, 3);
        pwm(2, 6, 4);

        repeat (60) begin
            h = $urandom_range(1, 10);
            l = $urandom_range(1, 10);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) en_nx = ~en_nx;
            pwm(h, l, n);
        end
        en_nx = 1'b1;
        pwm(5, 3, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
